register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised multi-port register file with same-cycle write-to-read bypass, an optional hardwired zero register, and a per-register pending (scoreboard) bit. It replaces the fixed 32x32, one-write/two-read register file in the decode stage. It supports superscalar/multi-writeback configurations and gives the hazard unit per-operand busy status directly.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NREGS, 32, number of registers (≥2); SEL_W = $clog2(NREGS)
- NREAD, 2, number of read ports
- NWRITE, 2, number of write ports; higher index = higher priority
- BYPASS, 1, 1 = write data forwarded to same-cycle reads
- ZERO_REG, 1, 1 = register 0 reads as 0, never written, never pending

Ports (port k occupies slice [k*W +: W]):
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- rsel  in  NREAD*SEL_W  read selects
- rdat  out  NREAD*DATA_W  read data (combinational)
- rbusy  out  NREAD  pending status of the selected register (combinational)
- wen  in  NWRITE  write enables
- wsel  in  NWRITE*SEL_W  write selects
- wdat  in  NWRITE*DATA_W  write data
- rsv_en  in  1  reserve request: mark rsv_sel pending
- rsv_sel  in  SEL_W  register to reserve
- wcollide  out  1  registered pulse: ≥2 enabled write ports targeted the same register last cycle

## Operation
- Storage: NREGS x DATA_W flops plus NREGS pending bits.
- Write: on each edge, for each register r, if any port k has wen[k] && wsel[k]==r, r takes wdat of the highest such k. Writes to r=0 are dropped when ZERO_REG=1.
- Pending set/clear per register r per edge:
  - set if rsv_en && rsv_sel==r;
  - else clear if any enabled write targets r;
  - else hold.
  - Reserve and write to the same r in one cycle: reserve wins, so pending stays 1 (the new producer supersedes the old one).
  - ZERO_REG=1: pending[0] is constant 0 and rsv_sel=0 is ignored.
- Read port j:
  - ZERO_REG && rsel==0: rdat=0, rbusy=0.
  - BYPASS && some enabled write port matches rsel: rdat = wdat of the highest matching port, and rbusy = 0 unless the same-cycle reserve also targets rsel. In that case rbusy = current pending bit (the reserve takes effect at the edge).
  - Otherwise: rdat = stored value, rbusy = pending[rsel].
  - BYPASS=0: rdat always equals the stored value. rbusy = pending[rsel], ignoring same-cycle writes.
- Collision: wcollide <= 1 at the edge after a cycle in which two or more enabled ports share a wsel (including 0), else 0.
- Out-of-range selects (value ≥ NREGS, non-power-of-2 NREGS):
  - reads return 0 with rbusy=0;
  - writes and reserves to them are dropped.

## Timing
- Read path fully combinational from rsel/wen/wsel/wdat; zero-cycle bypass latency.
- Write and pending updates are visible through non-bypass reads in the cycle after the write edge, i.e. 1-cycle latency.
- Reserve: rbusy rises the cycle after rsv_en is sampled.
- wcollide: 1-cycle registered latency, high for exactly one cycle per colliding cycle.
- Reset (RST=1 at an edge):
  - all registers <= 0, all pending <= 0, wcollide <= 0;
  - wen and rsv_en in the same cycle are ignored; reset has priority.
  - While RST=1, bypass is suppressed: rdat shows stored values and rbusy shows stored pending bits.
- Reset mid-operation: a register reserved but not yet written is cleared to not-pending. A write in the reset cycle is lost.
- Back-to-back: a write in cycle n and a read of the same register in n+1 returns the new value without bypass.

## Test plan
- Reset: preload r5=0xDEADBEEF and reserve r7, then hold RST=1 for one edge. Expect rdat=0 on all ports, rbusy=0 and wcollide=0 on the next cycle, with a same-cycle write to r3 ignored.
- Zero register (ZERO_REG=1): write 0x12345678 to r0 on port 0 and reserve r0. Expect r0 reads 0 with rbusy=0 in the same cycle and every later cycle.
- Bypass and priority: in one cycle write port0 r9=0xAAAA0000 and port1 r9=0x5555FFFF while reading r9. Expect rdat=0x5555FFFF in the same cycle and stored r9=0x5555FFFF next cycle. wcollide=1 for exactly one cycle. Repeat with BYPASS=0: the same-cycle read returns the old value.
- Scoreboard: reserve r4 in cycle 0, so rbusy(r4)=1 from cycle 1. Write r4=0x1 in cycle 3, so rbusy=0 in cycle 3 (bypass) and stays 0 from cycle 4. Reserve and write r4 together in cycle 6, so rbusy=1 from cycle 7.
- Multi-port independence (NREAD=4, NWRITE=2): write r1=0x11 and r2=0x22 in one cycle on separate ports, then read r1, r2, r1, r31 on four ports. Expect 0x11, 0x22, 0x11 and the r31 prior value, with wcollide=0.
- Reset mid-operation: reserve r10, assert RST before its write arrives, then release RST. Expect rbusy(r10)=0 and rdat(r10)=0.

Source files
------------

// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_mp_if
//  Purpose  : Bundles the read, write, reserve and collision signals of the
//             multi-port register file. Port k of a group occupies the slice
//             [k*W +: W] of the corresponding vector.
//  Modports : master - the decode/hazard logic driving selects and writes
//             slave  - the register file itself
//  Signals  : rsel/rdat/rbusy       read selects, read data, read busy
//             wen/wsel/wdat         write enables, selects, data
//             rsv_en/rsv_sel        reserve (scoreboard set) request
//             wcollide              registered same-target write collision
//  Revision : 1.0 - initial release
// ============================================================================
interface register_file_mp_if #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   parameter int NREAD  = 2,
   parameter int NWRITE = 2
);
   localparam int SEL_W = $clog2(NREGS);

   logic [NREAD*SEL_W-1:0]   rsel;
   logic [NREAD*DATA_W-1:0]  rdat;
   logic [NREAD-1:0]         rbusy;
   logic [NWRITE-1:0]        wen;
   logic [NWRITE*SEL_W-1:0]  wsel;
   logic [NWRITE*DATA_W-1:0] wdat;
   logic                     rsv_en;
   logic [SEL_W-1:0]         rsv_sel;
   logic                     wcollide;

   modport master (
      output rsel, wen, wsel, wdat, rsv_en, rsv_sel,
      input  rdat, rbusy, wcollide
   );

   modport slave (
      input  rsel, wen, wsel, wdat, rsv_en, rsv_sel,
      output rdat, rbusy, wcollide
   );
endinterface
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_mp
//  Purpose  : Parametrised multi-port register file with same-cycle
//             write-to-read bypass, optional hardwired zero register and a
//             per-register pending (scoreboard) bit.
//  Ports    : CLK  - clock, all state updates on the rising edge
//             RST  - synchronous active-high reset
//             bus  - register_file_mp_if.slave (reads, writes, reserve,
//                    collision flag)
//  Revision : 1.0 - initial release
// ============================================================================
module register_file_mp #(
   parameter int DATA_W   = 32,
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int NWRITE   = 2,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1
) (
   input  wire logic         CLK,
   input  wire logic         RST,
   register_file_mp_if.slave bus
);
   localparam int SEL_W = $clog2(NREGS);

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [NREGS-1:0]  r_pend;
   logic              r_wcollide;

   logic              w_wr_hit  [NREGS];
   logic [DATA_W-1:0] w_wr_data [NREGS];
   logic              w_rsv_hit [NREGS];
   logic              w_collide;

   // Per-register write decode. Ports are scanned low to high so the highest
   // matching port wins. Out-of-range selects match no register and drop out.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         w_wr_hit[r]  = 1'b0;
         w_wr_data[r] = '0;
         w_rsv_hit[r] = bus.rsv_en && (bus.rsv_sel == SEL_W'(r));
         for (int k = 0; k < NWRITE; k++) begin
            if (bus.wen[k] && (bus.wsel[k*SEL_W +: SEL_W] == SEL_W'(r))) begin
               w_wr_hit[r]  = 1'b1;
               w_wr_data[r] = bus.wdat[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Any two enabled write ports sharing a select, whatever the register.
   always_comb begin
      w_collide = 1'b0;
      for (int a = 0; a < NWRITE; a++) begin
         for (int b = a + 1; b < NWRITE; b++) begin
            if (bus.wen[a] && bus.wen[b] &&
                (bus.wsel[a*SEL_W +: SEL_W] == bus.wsel[b*SEL_W +: SEL_W])) begin
               w_collide = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int r = 0; r < NREGS; r++) begin
            r_regs[r] <= '0;
         end
         r_pend     <= '0;
         r_wcollide <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (ZERO_REG && (r == 0)) begin
               r_regs[r] <= '0;
               r_pend[r] <= 1'b0;
            end else begin
               if (w_wr_hit[r]) begin
                  r_regs[r] <= w_wr_data[r];
               end
               // A new reservation supersedes the producer writing back now.
               if (w_rsv_hit[r]) begin
                  r_pend[r] <= 1'b1;
               end else if (w_wr_hit[r]) begin
                  r_pend[r] <= 1'b0;
               end
            end
         end
         r_wcollide <= w_collide;
      end
   end

   assign bus.wcollide = r_wcollide;

   for (genvar j = 0; j < NREAD; j++) begin : g_rport
      logic [SEL_W-1:0]  w_sel;
      logic              w_in_range;
      logic [DATA_W-1:0] w_dat;
      logic              w_busy;
      logic              w_byp_hit;
      logic [DATA_W-1:0] w_byp_dat;

      assign w_sel = bus.rsel[j*SEL_W +: SEL_W];

      always_comb begin
         // Stored value via a full mux so out-of-range selects read 0/idle.
         w_in_range = 1'b0;
         w_dat      = '0;
         w_busy     = 1'b0;
         for (int r = 0; r < NREGS; r++) begin
            if (w_sel == SEL_W'(r)) begin
               w_in_range = 1'b1;
               w_dat      = r_regs[r];
               w_busy     = r_pend[r];
            end
         end

         w_byp_hit = 1'b0;
         w_byp_dat = '0;
         for (int k = 0; k < NWRITE; k++) begin
            if (bus.wen[k] && (bus.wsel[k*SEL_W +: SEL_W] == w_sel)) begin
               w_byp_hit = 1'b1;
               w_byp_dat = bus.wdat[k*DATA_W +: DATA_W];
            end
         end

         // Reset discards the writes, so forwarding them would be a lie.
         if (BYPASS && !RST && w_in_range && w_byp_hit) begin
            w_dat = w_byp_dat;
            // With a same-cycle reserve the register stays pending after the
            // edge, so keep reporting the current pending bit.
            if (!(bus.rsv_en && (bus.rsv_sel == w_sel))) begin
               w_busy = 1'b0;
            end
         end

         if (ZERO_REG && (w_sel == '0)) begin
            w_dat  = '0;
            w_busy = 1'b0;
         end
      end

      assign bus.rdat[j*DATA_W +: DATA_W] = w_dat;
      assign bus.rbusy[j]                 = w_busy;
   end
endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file_mp
//  Purpose  : Self-checking bench for register_file_mp. Instance u_a is a
//             4-read/2-write file with bypass and zero register; u_b is a
//             20-entry file without bypass or zero register.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 CLK = ~CLK;

   register_file_mp_if #(.DATA_W(32), .NREGS(32), .NREAD(4), .NWRITE(2)) bus_a ();
   register_file_mp_if #(.DATA_W(32), .NREGS(20), .NREAD(2), .NWRITE(2)) bus_b ();

   register_file_mp #(
      .DATA_W(32), .NREGS(32), .NREAD(4), .NWRITE(2), .BYPASS(1'b1), .ZERO_REG(1'b1)
   ) u_a (
      .CLK (CLK),
      .RST (RST),
      .bus (bus_a)
   );

   register_file_mp #(
      .DATA_W(32), .NREGS(20), .NREAD(2), .NWRITE(2), .BYPASS(1'b0), .ZERO_REG(1'b0)
   ) u_b (
      .CLK (CLK),
      .RST (RST),
      .bus (bus_b)
   );

   typedef struct {
      logic [1:0]   wen;
      logic [9:0]   wsel;
      logic [63:0]  wdat;
      logic         rsv_en;
      logic [4:0]   rsv_sel;
      logic [19:0]  rsel;
      logic [127:0] e_rdat;
      logic [3:0]   e_busy;
      logic         e_wc;
   } vec_t;

   localparam int NVEC = 17;
   vec_t tbl [NVEC];

   function automatic vec_t mk(
      input logic [1:0]  wen,
      input logic [4:0]  ws1, input logic [4:0] ws0,
      input logic [31:0] wd1, input logic [31:0] wd0,
      input logic        re,  input logic [4:0] rs,
      input logic [4:0]  r3, input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0,
      input logic [31:0] e3, input logic [31:0] e2, input logic [31:0] e1, input logic [31:0] e0,
      input logic [3:0]  eb, input logic ewc);
      vec_t v;
      v.wen     = wen;
      v.wsel    = {ws1, ws0};
      v.wdat    = {wd1, wd0};
      v.rsv_en  = re;
      v.rsv_sel = rs;
      v.rsel    = {r3, r2, r1, r0};
      v.e_rdat  = {e3, e2, e1, e0};
      v.e_busy  = eb;
      v.e_wc    = ewc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_a(input vec_t v);
      bus_a.wen     = v.wen;
      bus_a.wsel    = v.wsel;
      bus_a.wdat    = v.wdat;
      bus_a.rsv_en  = v.rsv_en;
      bus_a.rsv_sel = v.rsv_sel;
      bus_a.rsel    = v.rsel;
   endtask

   task automatic drive_b(input logic [1:0] wen, input logic [4:0] ws1, input logic [4:0] ws0,
                          input logic [31:0] wd1, input logic [31:0] wd0,
                          input logic re, input logic [4:0] rs,
                          input logic [4:0] r1, input logic [4:0] r0);
      bus_b.wen     = wen;
      bus_b.wsel    = {ws1, ws0};
      bus_b.wdat    = {wd1, wd0};
      bus_b.rsv_en  = re;
      bus_b.rsv_sel = rs;
      bus_b.rsel    = {r1, r0};
   endtask

   task automatic check_b(input int idx, input logic [31:0] e1, input logic [31:0] e0,
                          input logic [1:0] eb, input logic ewc);
      #3;
      chk($sformatf("b%0d rdat", idx), 128'(bus_b.rdat), 128'({e1, e0}));
      chk($sformatf("b%0d rbusy", idx), 128'(bus_b.rbusy), 128'(eb));
      chk($sformatf("b%0d wcollide", idx), 128'(bus_b.wcollide), 128'(ewc));
   endtask

   initial begin
      // Cycle-by-cycle table for u_a; reads are checked in the same cycle.
      tbl[0]  = mk(2'b11, 5'd9, 5'd9, 32'h5555FFFF, 32'hAAAA0000, 1'b0, 5'd0,
                   5'd31, 5'd9, 5'd0, 5'd9, 32'h0, 32'h5555FFFF, 32'h0, 32'h5555FFFF, 4'b0000, 1'b0);
      tbl[1]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
                   5'd9, 5'd9, 5'd9, 5'd9, 32'h5555FFFF, 32'h5555FFFF, 32'h5555FFFF, 32'h5555FFFF, 4'b0000, 1'b1);
      tbl[2]  = mk(2'b01, 5'd0, 5'd31, 32'h0, 32'hCAFEF00D, 1'b0, 5'd0,
                   5'd31, 5'd0, 5'd0, 5'd9, 32'hCAFEF00D, 32'h0, 32'h0, 32'h5555FFFF, 4'b0000, 1'b0);
      tbl[3]  = mk(2'b01, 5'd0, 5'd0, 32'h0, 32'h12345678, 1'b1, 5'd0,
                   5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0);
      tbl[4]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
                   5'd31, 5'd0, 5'd0, 5'd0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0);
      tbl[5]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4,
                   5'd0, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0);
      tbl[6]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
                   5'd0, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 1'b0);
      tbl[7]  = tbl[6];
      tbl[8]  = mk(2'b10, 5'd4, 5'd0, 32'h1, 32'h0, 1'b0, 5'd0,
                   5'd0, 5'd0, 5'd4, 5'd4, 32'h0, 32'h0, 32'h1, 32'h1, 4'b0000, 1'b0);
      tbl[9]  = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
                   5'd0, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 32'h1, 4'b0000, 1'b0);
      tbl[10] = tbl[9];
      tbl[11] = mk(2'b01, 5'd0, 5'd4, 32'h0, 32'h2, 1'b1, 5'd4,
                   5'd0, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 32'h2, 4'b0000, 1'b0);
      tbl[12] = mk(2'b01, 5'd0, 5'd4, 32'h0, 32'h3, 1'b1, 5'd4,
                   5'd0, 5'd0, 5'd9, 5'd4, 32'h0, 32'h0, 32'h5555FFFF, 32'h3, 4'b0001, 1'b0);
      tbl[13] = mk(2'b11, 5'd2, 5'd1, 32'h22, 32'h11, 1'b0, 5'd0,
                   5'd31, 5'd2, 5'd1, 5'd4, 32'hCAFEF00D, 32'h22, 32'h11, 32'h3, 4'b0001, 1'b0);
      tbl[14] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
                   5'd31, 5'd1, 5'd2, 5'd1, 32'hCAFEF00D, 32'h11, 32'h22, 32'h11, 4'b0000, 1'b0);
      tbl[15] = mk(2'b11, 5'd0, 5'd0, 32'h88, 32'h77, 1'b0, 5'd0,
                   5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0);
      tbl[16] = mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0,
                   5'd0, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 32'h3, 4'b0001, 1'b1);

      apply_a(mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0));
      drive_b(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;

      // Reset state
      bus_a.rsel = {5'd31, 5'd9, 5'd5, 5'd1};
      #3;
      chk("reset rdat", 128'(bus_a.rdat), 128'h0);
      chk("reset rbusy", 128'(bus_a.rbusy), 128'h0);
      chk("reset wcollide", 128'(bus_a.wcollide), 128'h0);
      step();

      for (int i = 0; i < NVEC; i++) begin
         apply_a(tbl[i]);
         #3;
         chk($sformatf("vec%0d rdat", i), bus_a.rdat, tbl[i].e_rdat);
         chk($sformatf("vec%0d rbusy", i), 128'(bus_a.rbusy), 128'(tbl[i].e_busy));
         chk($sformatf("vec%0d wcollide", i), 128'(bus_a.wcollide), 128'(tbl[i].e_wc));
         step();
      end

      // Reset with preloaded state: r5 written, r7 reserved, r4 still pending.
      apply_a(mk(2'b01, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b1, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0,
                 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0));
      step();
      // Reset cycle carries a colliding write to r3 and a reserve of r8.
      RST = 1'b1;
      apply_a(mk(2'b11, 5'd3, 5'd3, 32'h2, 32'h1, 1'b1, 5'd8, 5'd4, 5'd5, 5'd7, 5'd3,
                 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0));
      #3;
      chk("in-reset rdat", bus_a.rdat, {32'h3, 32'hDEADBEEF, 32'h0, 32'h0});
      chk("in-reset rbusy", 128'(bus_a.rbusy), 128'(4'b1010));
      step();
      RST = 1'b0;
      apply_a(mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd5, 5'd7, 5'd8,
                 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 1'b0));
      bus_a.rsel = {5'd4, 5'd5, 5'd7, 5'd3};
      #3;
      chk("post-reset rdat", bus_a.rdat, 128'h0);
      chk("post-reset rbusy", 128'(bus_a.rbusy), 128'h0);
      chk("post-reset wcollide", 128'(bus_a.wcollide), 128'h0);
      bus_a.rsel = {5'd0, 5'd0, 5'd0, 5'd8};
      #1;
      chk("post-reset r8 rbusy", 128'(bus_a.rbusy), 128'h0);
      step();

      // Reset while r10 is reserved and unwritten.
      bus_a.rsv_en  = 1'b1;
      bus_a.rsv_sel = 5'd10;
      bus_a.rsel    = {5'd0, 5'd0, 5'd0, 5'd10};
      step();
      bus_a.rsv_en = 1'b0;
      #3;
      chk("r10 reserved rbusy", 128'(bus_a.rbusy[0]), 128'h1);
      RST = 1'b1;
      step();
      RST = 1'b0;
      #3;
      chk("r10 after reset rbusy", 128'(bus_a.rbusy[0]), 128'h0);
      chk("r10 after reset rdat", 128'(bus_a.rdat[31:0]), 128'h0);
      step();

      // u_b: no bypass, no zero register, 20 entries.
      drive_b(2'b01, 5'd0, 5'd9, 32'h0, 32'h1, 1'b0, 5'd0, 5'd0, 5'd9);
      check_b(0, 32'h0, 32'h0, 2'b00, 1'b0);
      step();
      drive_b(2'b11, 5'd9, 5'd9, 32'h5555FFFF, 32'hAAAA0000, 1'b0, 5'd0, 5'd0, 5'd9);
      check_b(1, 32'h0, 32'h1, 2'b00, 1'b0);
      step();
      drive_b(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9);
      check_b(2, 32'h0, 32'h5555FFFF, 2'b00, 1'b1);
      step();
      drive_b(2'b11, 5'd25, 5'd0, 32'hFFFFFFFF, 32'h0000ABCD, 1'b1, 5'd9, 5'd25, 5'd9);
      check_b(3, 32'h0, 32'h5555FFFF, 2'b00, 1'b0);
      step();
      drive_b(2'b01, 5'd0, 5'd9, 32'h0, 32'h7, 1'b0, 5'd0, 5'd0, 5'd9);
      check_b(4, 32'h0000ABCD, 32'h5555FFFF, 2'b01, 1'b0);
      step();
      drive_b(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd21, 5'd25, 5'd9);
      check_b(5, 32'h0, 32'h7, 2'b00, 1'b0);
      step();
      drive_b(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd21);
      check_b(6, 32'h0, 32'h0, 2'b00, 1'b0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
